// File: rtl/axis_master_pkt.sv
// -----------------------------------------------------------------------------
// axis_master_pkt
// AXI4-Stream master for the MLP output path. Result words from the MLP core
// are buffered in a first-word-fall-through FIFO and streamed out in packets of
// C_PACKET_LEN beats with a generated TLAST.
//
// Parameters
//   C_M_AXIS_TDATA_WIDTH : word width (multiple of 8)
//   C_FIFO_DEPTH         : FIFO entries (power of two, >= 2)
//   C_PACKET_LEN         : beats per packet
//   C_STORE_AND_FORWARD  : 1 = a packet starts only once all its words are stored
//
// Ports
//   M_AXIS_ACLK, M_AXIS_ARESET : clock, synchronous active-high reset
//   pi_mlp_data, pi_write_to_fifo : write side from the MLP core
//   po_wr_fifo_done  : one-cycle pulse after the last word of a packet is stored
//   po_fifo_full, po_fifo_level : FIFO status
//   M_AXIS_*         : AXI4-Stream master (TSTRB constant all ones)
//   po_overflow      : sticky dropped-write flag, only when the macro
//                      AXIS_MASTER_OVERFLOW_EN is defined
// -----------------------------------------------------------------------------
module axis_master_pkt #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int C_FIFO_DEPTH         = 16,
    parameter int C_PACKET_LEN         = 8,
    parameter int C_STORE_AND_FORWARD  = 0
) (
    input  logic                                M_AXIS_ACLK,
    input  logic                                M_AXIS_ARESET,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     pi_mlp_data,
    input  logic                                pi_write_to_fifo,
    output logic                                po_wr_fifo_done,
    output logic                                po_fifo_full,
    output logic [$clog2(C_FIFO_DEPTH):0]       po_fifo_level,
    input  logic                                M_AXIS_TREADY,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
    output logic                                M_AXIS_TLAST,
`ifdef AXIS_MASTER_OVERFLOW_EN
    output logic                                po_overflow,
`endif
    output logic                                M_AXIS_TVALID
);

    localparam int PTR_W  = $clog2(C_FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int BEAT_W = (C_PACKET_LEN > 1) ? $clog2(C_PACKET_LEN) : 1;
    // One spare bit: in cut-through mode a packet can be counted while its
    // words are already leaving, so the count may exceed level/C_PACKET_LEN.
    localparam int PKT_W  = LVL_W + 1;

    localparam logic [LVL_W-1:0]  DEPTH_LVL = LVL_W'(C_FIFO_DEPTH);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(C_PACKET_LEN - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    logic [C_M_AXIS_TDATA_WIDTH-1:0] mem_r [C_FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [LVL_W-1:0]  level_r;
    logic [BEAT_W-1:0] wr_beat_r;
    logic [BEAT_W-1:0] rd_beat_r;
    logic [PKT_W-1:0]  pkt_cnt_r;
    logic              done_r;
    state_t            state_r;
    state_t            next_state_s;

    logic wr_en_s;
    logic rd_en_s;
    logic start_s;
    logic pkt_done_s;
    logic tvalid_s;
    logic tlast_s;
    logic last_hs_s;

    // Write acceptance, start condition and handshake decode plus FSM next state.
    always_comb begin
        next_state_s = state_r;
        tvalid_s     = 1'b0;
        // Acceptance looks only at the pre-edge level: a same-cycle read never
        // frees a slot for this cycle's write.
        wr_en_s      = pi_write_to_fifo && (level_r < DEPTH_LVL);
        pkt_done_s   = wr_en_s && (wr_beat_r == LAST_BEAT);
        if (C_STORE_AND_FORWARD != 0) begin
            start_s = (pkt_cnt_r != PKT_W'(0));
        end else begin
            start_s = (level_r != LVL_W'(0));
        end
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    next_state_s = ST_SEND;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                tvalid_s = (level_r != LVL_W'(0));
                if (tvalid_s && M_AXIS_TREADY && (rd_beat_r == LAST_BEAT)) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_SEND;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
        tlast_s   = tvalid_s && (rd_beat_r == LAST_BEAT);
        rd_en_s   = tvalid_s && M_AXIS_TREADY;
        last_hs_s = rd_en_s && tlast_s;
    end

    // FIFO storage; cleared on reset so TDATA reads zero afterwards.
    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) begin
            for (int i = 0; i < C_FIFO_DEPTH; i++) begin
                mem_r[i] <= {C_M_AXIS_TDATA_WIDTH{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_r[wr_ptr_r] <= pi_mlp_data;
        end
    end

    // FIFO pointers and fill level.
    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            level_r  <= LVL_W'(0);
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Write/read beat counters, complete-packet counter and done pulse.
    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) begin
            wr_beat_r <= BEAT_W'(0);
            rd_beat_r <= BEAT_W'(0);
            pkt_cnt_r <= PKT_W'(0);
            done_r    <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_beat_r <= pkt_done_s ? BEAT_W'(0) : (wr_beat_r + BEAT_W'(1));
            end
            if (rd_en_s) begin
                rd_beat_r <= tlast_s ? BEAT_W'(0) : (rd_beat_r + BEAT_W'(1));
            end
            case ({pkt_done_s, last_hs_s})
                2'b10:   pkt_cnt_r <= pkt_cnt_r + PKT_W'(1);
                2'b01:   pkt_cnt_r <= pkt_cnt_r - PKT_W'(1);
                default: pkt_cnt_r <= pkt_cnt_r;
            endcase
            done_r <= pkt_done_s;
        end
    end

    // FSM state register.
    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

`ifdef AXIS_MASTER_OVERFLOW_EN
    logic overflow_r;

    // Sticky flag for any write attempted against a full FIFO.
    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) begin
            overflow_r <= 1'b0;
        end else if (pi_write_to_fifo && (level_r == DEPTH_LVL)) begin
            overflow_r <= 1'b1;
        end
    end

    assign po_overflow = overflow_r;
`endif

    // Stream outputs are decoded from registered state only (no input paths).
    assign M_AXIS_TVALID   = tvalid_s;
    assign M_AXIS_TLAST    = tlast_s;
    assign M_AXIS_TDATA    = mem_r[rd_ptr_r];
    assign M_AXIS_TSTRB    = {(C_M_AXIS_TDATA_WIDTH/8){1'b1}};
    assign po_fifo_level   = level_r;
    assign po_fifo_full    = (level_r == DEPTH_LVL);
    assign po_wr_fifo_done = done_r;

endmodule

// File: tb/tb_axis_master_pkt.sv
// -----------------------------------------------------------------------------
// Self-checking bench for axis_master_pkt. Three instances:
//   d0 : defaults (32-bit, depth 16, 8-beat packets, cut-through) checked each
//        cycle against a queue-based reference model
//   d1 : store-and-forward, hand-written sequence
//   d2 : 64-bit, depth 2, 1-beat packets, table-driven vectors
// -----------------------------------------------------------------------------
module tb_axis_master_pkt;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // d0
    logic        wr0 = 1'b0, tr0 = 1'b0;
    logic [31:0] data0 = 32'h0;
    logic        done0, full0, last0, valid0;
    logic [4:0]  lvl0;
    logic [31:0] tdata0;
    logic [3:0]  strb0;
    // d1
    logic        wr1 = 1'b0, tr1 = 1'b0;
    logic [31:0] data1 = 32'h0;
    logic        done1, full1, last1, valid1;
    logic [4:0]  lvl1;
    logic [31:0] tdata1;
    logic [3:0]  strb1;
    // d2
    logic        wr2 = 1'b0, tr2 = 1'b0;
    logic [63:0] data2 = 64'h0;
    logic        done2, full2, last2, valid2;
    logic [1:0]  lvl2;
    logic [63:0] tdata2;
    logic [7:0]  strb2;
`ifdef AXIS_MASTER_OVERFLOW_EN
    logic ovf0, ovf1, ovf2;
`endif

    axis_master_pkt d0 (
        .M_AXIS_ACLK(clk), .M_AXIS_ARESET(rst),
        .pi_mlp_data(data0), .pi_write_to_fifo(wr0),
        .po_wr_fifo_done(done0), .po_fifo_full(full0), .po_fifo_level(lvl0),
        .M_AXIS_TREADY(tr0), .M_AXIS_TDATA(tdata0), .M_AXIS_TSTRB(strb0),
        .M_AXIS_TLAST(last0),
`ifdef AXIS_MASTER_OVERFLOW_EN
        .po_overflow(ovf0),
`endif
        .M_AXIS_TVALID(valid0));

    axis_master_pkt #(.C_STORE_AND_FORWARD(1)) d1 (
        .M_AXIS_ACLK(clk), .M_AXIS_ARESET(rst),
        .pi_mlp_data(data1), .pi_write_to_fifo(wr1),
        .po_wr_fifo_done(done1), .po_fifo_full(full1), .po_fifo_level(lvl1),
        .M_AXIS_TREADY(tr1), .M_AXIS_TDATA(tdata1), .M_AXIS_TSTRB(strb1),
        .M_AXIS_TLAST(last1),
`ifdef AXIS_MASTER_OVERFLOW_EN
        .po_overflow(ovf1),
`endif
        .M_AXIS_TVALID(valid1));

    axis_master_pkt #(.C_M_AXIS_TDATA_WIDTH(64), .C_FIFO_DEPTH(2), .C_PACKET_LEN(1)) d2 (
        .M_AXIS_ACLK(clk), .M_AXIS_ARESET(rst),
        .pi_mlp_data(data2), .pi_write_to_fifo(wr2),
        .po_wr_fifo_done(done2), .po_fifo_full(full2), .po_fifo_level(lvl2),
        .M_AXIS_TREADY(tr2), .M_AXIS_TDATA(tdata2), .M_AXIS_TSTRB(strb2),
        .M_AXIS_TLAST(last2),
`ifdef AXIS_MASTER_OVERFLOW_EN
        .po_overflow(ovf2),
`endif
        .M_AXIS_TVALID(valid2));

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int ndone = 0;

    // Beats observed on d0: data, TLAST, and cycle index of the handshake.
    logic [31:0] bd[$];
    logic        bl[$];
    int          bc[$];

    // Reference model for d0: queue of stored words plus packet bookkeeping.
    logic [31:0] mq[$];
    bit m_send, m_done, m_ovf;
    int m_rbeat, m_wbeat;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        bd.delete(); bl.delete(); bc.delete(); ndone = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr0 = 1'b0; tr0 = 1'b0; data0 = 32'h0;
        wr1 = 1'b0; tr1 = 1'b0; data1 = 32'h0;
        wr2 = 1'b0; tr2 = 1'b0; data2 = 64'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        mq.delete();
        m_send = 1'b0; m_done = 1'b0; m_ovf = 1'b0;
        m_rbeat = 0; m_wbeat = 0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_d0_valid", valid0, 0); chk("rst_d0_last", last0, 0);
        chk("rst_d0_data", tdata0, 0);  chk("rst_d0_level", lvl0, 0);
        chk("rst_d0_full", full0, 0);   chk("rst_d0_done", done0, 0);
        chk("rst_d0_strb", strb0, 4'hF);
        chk("rst_d1_valid", valid1, 0); chk("rst_d1_level", lvl1, 0);
        chk("rst_d1_data", tdata1, 0);  chk("rst_d1_strb", strb1, 4'hF);
        chk("rst_d2_valid", valid2, 0); chk("rst_d2_level", lvl2, 0);
        chk("rst_d2_data", tdata2, 0);  chk("rst_d2_strb", strb2, 8'hFF);
`ifdef AXIS_MASTER_OVERFLOW_EN
        chk("rst_d0_ovf", ovf0, 0); chk("rst_d1_ovf", ovf1, 0); chk("rst_d2_ovf", ovf2, 0);
`endif
    endtask

    // One clock of d0: drive, advance model, compare after the edge.
    task automatic cyc0(input logic wr, input logic [31:0] d, input logic tr);
        logic pv, pl;
        logic [31:0] pd;
        bit mv, ml, hs, ev, el;
        int sz;
        wr0 = wr; data0 = d; tr0 = tr;
        pv = valid0; pl = last0; pd = tdata0;
        if (pv && tr) begin
            bd.push_back(pd); bl.push_back(pl); bc.push_back(cyc);
        end
        sz = mq.size();
        mv = m_send && (sz > 0);
        ml = mv && (m_rbeat == 7);
        hs = mv && tr;
        if (wr && sz == 16) m_ovf = 1'b1;
        if (!m_send) m_send = (sz > 0);
        else if (hs && ml) m_send = 1'b0;
        if (hs) begin
            void'(mq.pop_front());
            m_rbeat = ml ? 0 : m_rbeat + 1;
        end
        if (wr && sz < 16) begin
            mq.push_back(d);
            m_done = (m_wbeat == 7);
            m_wbeat = (m_wbeat + 1) % 8;
        end else begin
            m_done = 1'b0;
        end
        @(posedge clk); #1;
        cyc++;
        ev = m_send && (mq.size() > 0);
        el = ev && (m_rbeat == 7);
        chk("d0_tvalid", valid0, ev);
        chk("d0_tlast", last0, el);
        if (ev) chk("d0_tdata", tdata0, mq[0]);
        chk("d0_level", lvl0, mq.size());
        chk("d0_full", full0, mq.size() == 16);
        chk("d0_done", done0, m_done);
`ifdef AXIS_MASTER_OVERFLOW_EN
        chk("d0_overflow", ovf0, m_ovf);
`endif
        if (pv && !tr) begin
            chk("stall_tdata_stable", tdata0, pd);
            chk("stall_tlast_stable", last0, pl);
        end
        if (done0) ndone++;
    endtask

    task automatic cyc1(input logic wr, input logic [31:0] d, input logic tr);
        wr1 = wr; data1 = d; tr1 = tr;
        @(posedge clk); #1;
        cyc++;
    endtask

    typedef struct {
        logic        wr;
        logic [63:0] d;
        logic        tr;
        logic        v;
        logic        l;
        logic [1:0]  lvl;
        logic        full;
        logic        done;
        logic [63:0] ed;
    } vec_t;

    vec_t tbl[10];

    initial begin
        // d2 vectors: depth 2, one-beat packets; expectations after each edge.
        tbl[0] = '{1'b1, 64'hA5A5_0000_0000_0001, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 64'h0};
        tbl[1] = '{1'b1, 64'hB6B6_0000_0000_0002, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 64'hA5A5_0000_0000_0001};
        tbl[2] = '{1'b1, 64'hC7C7_0000_0000_0003, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 64'hA5A5_0000_0000_0001};
        tbl[3] = '{1'b0, 64'h0,                   1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 64'h0};
        tbl[4] = '{1'b0, 64'h0,                   1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 64'hB6B6_0000_0000_0002};
        tbl[5] = '{1'b1, 64'hD8D8_0000_0000_0004, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 64'h0};
        tbl[6] = '{1'b0, 64'h0,                   1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 64'hD8D8_0000_0000_0004};
        tbl[7] = '{1'b0, 64'h0,                   1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 64'hD8D8_0000_0000_0004};
        tbl[8] = '{1'b0, 64'h0,                   1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 64'h0};
        tbl[9] = '{1'b0, 64'h0,                   1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 64'h0};

        do_reset();
        chk_reset_outputs();

        // Test 1: continuous writes, TREADY=1.
        clear_logs();
        for (int i = 0; i < 16; i++) cyc0(1'b1, 32'(12 * i), 1'b1);
        for (int i = 0; i < 12; i++) cyc0(1'b0, 32'h0, 1'b1);
        chk("t1_beats", bd.size(), 16);
        for (int i = 0; i < bd.size(); i++) begin
            chk("t1_data", bd[i], 32'(12 * i));
            chk("t1_last", bl[i], (i % 8) == 7);
        end
        if (bd.size() == 16) begin
            chk("t1_pkt0_back_to_back", bc[7] - bc[0], 7);
            chk("t1_one_idle_gap", bc[8] - bc[7], 2);
            chk("t1_pkt1_back_to_back", bc[15] - bc[8], 7);
        end
        chk("t1_done_pulses", ndone, 2);

        // Test 2: same words with random TREADY.
        do_reset();
        clear_logs();
        for (int i = 0; i < 16; i++) cyc0(1'b1, 32'(12 * i), $urandom_range(0, 1) == 1);
        for (int i = 0; i < 60; i++) cyc0(1'b0, 32'h0, $urandom_range(0, 1) == 1);
        for (int i = 0; i < 20; i++) cyc0(1'b0, 32'h0, 1'b1);
        chk("t2_beats", bd.size(), 16);
        for (int i = 0; i < bd.size(); i++) begin
            chk("t2_data", bd[i], 32'(12 * i));
            chk("t2_last", bl[i], (i % 8) == 7);
        end

        // Test 3: fill past capacity with TREADY=0, then drain.
        do_reset();
        clear_logs();
        for (int i = 0; i < 20; i++) cyc0(1'b1, 32'(i + 1), 1'b0);
        chk("t3_level_sat", lvl0, 16);
        chk("t3_full", full0, 1);
`ifdef AXIS_MASTER_OVERFLOW_EN
        chk("t3_overflow", ovf0, 1);
`endif
        for (int i = 0; i < 40; i++) cyc0(1'b0, 32'h0, 1'b1);
        chk("t3_beats", bd.size(), 16);
        if (bd.size() == 16) begin
            chk("t3_final_word", bd[15], 16);
            chk("t3_final_last", bl[15], 1);
            chk("t3_mid_last", bl[7], 1);
        end

        // Test 5: reset after three beats of a packet have gone out.
        do_reset();
        clear_logs();
        for (int i = 0; i < 5; i++) cyc0(1'b1, 32'h100 + 32'(i), 1'b1);
        chk("t5_beats_before_reset", bd.size(), 3);
        do_reset();
        chk_reset_outputs();
        clear_logs();
        for (int i = 0; i < 8; i++) cyc0(1'b1, 32'h200 + 32'(i), 1'b1);
        for (int i = 0; i < 15; i++) cyc0(1'b0, 32'h0, 1'b1);
        chk("t5_beats_after_reset", bd.size(), 8);
        for (int i = 0; i < bd.size(); i++) begin
            chk("t5_data", bd[i], 32'h200 + 32'(i));
            chk("t5_last", bl[i], i == 7);
        end

        // Test 6: one-beat packets, depth 2, 64-bit, table-driven.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            wr2 = tbl[i].wr; data2 = tbl[i].d; tr2 = tbl[i].tr;
            @(posedge clk); #1;
            cyc++;
            chk("t6_tvalid", valid2, tbl[i].v);
            chk("t6_tlast", last2, tbl[i].l);
            chk("t6_level", lvl2, tbl[i].lvl);
            chk("t6_full", full2, tbl[i].full);
            chk("t6_done", done2, tbl[i].done);
            chk("t6_tstrb", strb2, 8'hFF);
            if (tbl[i].v) chk("t6_tdata", tdata2, tbl[i].ed);
        end
        wr2 = 1'b0; tr2 = 1'b0;

        // Test 4: store-and-forward holds TVALID until the packet is complete.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cyc1(1'b1, 32'(100 + i), 1'b1);
            chk("t4_valid_held", valid1, 0);
            chk("t4_level", lvl1, i + 1);
        end
        cyc1(1'b1, 32'd107, 1'b1);
        chk("t4_valid_at_accept", valid1, 0);
        chk("t4_done", done1, 1);
        cyc1(1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            chk("t4_tvalid", valid1, 1);
            chk("t4_tdata", tdata1, 32'(100 + k));
            chk("t4_tlast", last1, k == 7);
            cyc1(1'b0, 32'h0, 1'b1);
        end
        chk("t4_idle_after", valid1, 0);
        chk("t4_empty_after", lvl1, 0);
        tr1 = 1'b0;

        // Random traffic on d0 against the model.
        do_reset();
        for (int i = 0; i < 300; i++) cyc0($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 3) != 0);
        for (int i = 0; i < 200; i++) cyc0($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 3) == 0);
        for (int i = 0; i < 50; i++) cyc0(1'b0, 32'h0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
